// File: rtl/button_pio_seq_pkg.sv
// Shared state encoding and PIO register map for the button PIO interrupt sequencer.
package button_pio_seq_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_EDGE,
        CLR_EDGE,
        RD_LVL,
        PUSH
    } seq_state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/pio_event_fifo.sv
// Synchronous first-word-fall-through FIFO for button events.
// Latency: a pushed word is visible on rd_dat the cycle after the push.
// Backpressure: writes while full and reads while empty are ignored; full/empty exported to the producer.
module pio_event_fifo #(
    parameter int WIDTH_D = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_vld,
    input  logic [WIDTH_D-1:0] wr_dat,
    input  logic               rd_rdy,
    output logic [WIDTH_D-1:0] rd_dat,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [WIDTH_D-1:0] mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_vld && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_rdy && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/button_pio_irq_sequencer.sv
// Avalon-MM master for the button PIO: programs irq_mask, services pio_irq into {levels,edges} events.
// Latency: an irq seen in IDLE yields an event 2*READ_LATENCY+5 cycles later.
// Backpressure: a full event FIFO parks the FSM in IDLE; edges keep accumulating in the slave.
module button_pio_irq_sequencer
    import button_pio_seq_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [WIDTH-1:0]   irq_mask_cfg,
    output logic [1:0]         pio_address,
    output logic               pio_chipselect,
    output logic               pio_write_n,
    output logic [31:0]        pio_writedata,
    input  logic [31:0]        pio_readdata,
    input  logic               pio_irq,
    output logic               evt_valid,
    output logic [2*WIDTH-1:0] evt_data,
    input  logic               evt_ready,
    output logic               busy
);

    localparam int CNT_W = $clog2(READ_LATENCY + 2);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LATENCY);

    seq_state_t         state;
    logic [WIDTH-1:0]   mask_shadow;
    logic [WIDTH-1:0]   edges;
    logic [WIDTH-1:0]   levels;
    logic [CNT_W-1:0]   rd_cnt;
    logic [WIDTH-1:0]   target_mask;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_dat;
    logic               unused_rd_bits;

    assign target_mask    = enable ? irq_mask_cfg : '0;
    assign fifo_push      = (state == PUSH) && (edges != '0);
    assign evt_valid      = !fifo_empty;
    assign evt_data       = evt_valid ? fifo_dat : '0;
    assign unused_rd_bits = ^pio_readdata[31:WIDTH];

    pio_event_fifo #(
        .WIDTH_D (2 * WIDTH),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (fifo_push),
        .wr_dat  ({levels, edges}),
        .rd_rdy  (evt_ready),
        .rd_dat  (fifo_dat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= INIT;
            pio_address    <= ADDR_DATA;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            mask_shadow    <= '0;
            edges          <= '0;
            levels         <= '0;
            rd_cnt         <= '0;
            busy           <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    // First cycle launches the write; the cycle it is on the bus retires it.
                    if (!pio_chipselect) begin
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_address    <= ADDR_MASK;
                        pio_writedata  <= 32'(target_mask);
                        mask_shadow    <= target_mask;
                        busy           <= 1'b1;
                    end else begin
                        pio_chipselect <= 1'b0;
                        pio_write_n    <= 1'b1;
                        pio_writedata  <= '0;
                        state          <= IDLE;
                        busy           <= 1'b0;
                    end
                end
                IDLE: begin
                    if (target_mask != mask_shadow) begin
                        state <= INIT;
                        busy  <= 1'b1;
                    end else if (enable && pio_irq && !fifo_full) begin
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b1;
                        pio_address    <= ADDR_EDGE;
                        rd_cnt         <= '0;
                        state          <= RD_EDGE;
                        busy           <= 1'b1;
                    end
                end
                RD_EDGE: begin
                    if (rd_cnt == RD_LAST) begin
                        edges         <= pio_readdata[WIDTH-1:0];
                        pio_write_n   <= 1'b0;
                        pio_writedata <= '0;
                        state         <= CLR_EDGE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                CLR_EDGE: begin
                    pio_write_n <= 1'b1;
                    pio_address <= ADDR_DATA;
                    rd_cnt      <= '0;
                    state       <= RD_LVL;
                end
                RD_LVL: begin
                    if (rd_cnt == RD_LAST) begin
                        levels         <= pio_readdata[WIDTH-1:0];
                        pio_chipselect <= 1'b0;
                        state          <= PUSH;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                PUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    state          <= INIT;
                    busy           <= 1'b1;
                end
            endcase
        end
    end

endmodule
